alu_pipe: RTL and testbench
===========================

// Module: alu_pipe
// PURPOSE
//  Parametrised, pipelined successor to the combinational LED-driving ALU: same MIPS-funct opcode set plus SLL/SLT/SLTU.
//  Adds status flags, an illegal-op error flag, and a valid/ready handshake with backpressure.
//  Sits between the operand-entry front end (switch/UART loader) and the result consumer (LED/display/UART TX).
//  Latency 2 cycles, one operation per cycle when not stalled.
// PARAMETERS
//  DATA_W   8   operand/result width in bits (>=4); shift amount = B[$clog2(DATA_W)-1:0]
//  OP_W     6   opcode width (MIPS funct field)
// PORTS
//  clk        in   1        single clock, rising edge
//  reset      in   1        asynchronous, active-high; clears all state
//  in_valid   in   1        Op/A/B valid this cycle
//  in_ready   out  1        block accepts Op/A/B this cycle (transfer = in_valid & in_ready)
//  Op         in   OP_W     operation code
//  A          in   DATA_W   operand A, two's complement
//  B          in   DATA_W   operand B, two's complement
//  out_valid  out  1        result/flags valid
//  out_ready  in   1        consumer takes result (transfer = out_valid & out_ready)
//  Result     out  DATA_W   operation result
//  flag_z     out  1        Result == 0
//  flag_n     out  1        Result[DATA_W-1]
//  flag_c     out  1        ADD: carry out; SUB: NOT borrow (A>=B unsigned); else 0
//  flag_v     out  1        ADD/SUB signed overflow; else 0
//  err        out  1        Op was illegal
// BEHAVIOUR
//  - Opcodes: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR,
//    000011 SRA (A>>>sh), 000010 SRL (A>>sh), 000100 SLL (A<<sh), 101010 SLT (signed A<B ? 1:0),
//    101011 SLTU (unsigned), 000000 pass A, 000001 pass B.
//  - Any other Op: Result = all ones, err=1, flag_c=flag_v=0, flag_z/flag_n computed from Result.
//  - Add/sub computed at DATA_W+1 bits; Result = low DATA_W bits (wrap-around, no saturation).
//  - Stage 1 (S1): registers Op/A/B on accept; s1_valid flag.
//  - Stage 2 (S2): registers alu_core output + flags; out_valid = s2_valid.
//  - Enables: s2_en = !out_valid | out_ready; s1_en = !s1_valid | s2_en; in_ready = s1_en.
//    in_ready depends combinationally on out_ready; no other comb in->out path.
//  - On s2_en: S2 <= S1 contents, s2_valid <= s1_valid. On s1_en: S1 <= inputs, s1_valid <= in_valid.
//  - Latency: accept at edge k -> out_valid high after edge k+1 when not stalled.
//  - Stall: out_valid & !out_ready holds S2. If S1 also holds a valid op, S1 holds and in_ready=0.
//    Max 2 ops in flight; order preserved; no drop or duplication.
//  - Bubbles collapse: empty S2 accepts S1 even while out_ready=0.
//  - Simultaneous output take and input accept in the same cycle: full throughput.
//  - Result/flags stay stable while out_valid & !out_ready.
//  - Reset (any time, incl. mid-operation): s1_valid=s2_valid=0; Result=0, all flags=0, err=0;
//    in_ready=1 in the first cycle after reset deasserts. In-flight ops are discarded.
//  - Data registers with valid=0 are don't-care internally, but outputs Result/flags hold their last value.
// STRUCTURE
//  - alu_pkg: opcode localparams (OP_ADD..OP_PASSB), OP_W.
//  - Sub-module alu_core (combinational, params DATA_W/OP_W): Op,A,B -> Result,c,v,err.
//    alu_pipe owns the handshake, both register stages and z/n derivation.
// TESTING (DATA_W=8, out_ready=1 unless stated)
//  1 ADD A=0x7F B=0x01 -> Result 0x80, n=1 v=1 c=0 z=0, out_valid 2 cycles after accept
//  2 SUB A=0x05 B=0x05 -> 0x00 z=1 c=1 v=0; SUB A=0x00 B=0x01 -> 0xFF c=0 n=1
//  3 SRA A=0x80 B=0x0B (sh=3) -> 0xF0; SRL same -> 0x10; SLT A=0xFF B=0x01 -> 0x01; SLTU -> 0x00
//  4 Op=6'b111111 A=0x12 B=0x34 -> Result 0xFF, err=1, n=1; next legal op -> err=0
//  5 Back-to-back stream of 5 ADDs, out_ready low 4 cycles from the 2nd result -> in_ready drops
//    once 2 ops are buffered; all 5 results emerge in order, each exactly once
//  6 Assert reset with 2 ops in flight -> out_valid=0, Result=0 immediately (async); no stale output after release

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode encodings (MIPS funct field) shared by the ALU pipeline
package alu_pkg;
    localparam int OP_W = 6;

    localparam logic [OP_W-1:0] OP_PASSA = 6'b000000;
    localparam logic [OP_W-1:0] OP_PASSB = 6'b000001;
    localparam logic [OP_W-1:0] OP_SRL   = 6'b000010;
    localparam logic [OP_W-1:0] OP_SRA   = 6'b000011;
    localparam logic [OP_W-1:0] OP_SLL   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADD   = 6'b100000;
    localparam logic [OP_W-1:0] OP_SUB   = 6'b100010;
    localparam logic [OP_W-1:0] OP_AND   = 6'b100100;
    localparam logic [OP_W-1:0] OP_OR    = 6'b100101;
    localparam logic [OP_W-1:0] OP_XOR   = 6'b100110;
    localparam logic [OP_W-1:0] OP_NOR   = 6'b100111;
    localparam logic [OP_W-1:0] OP_SLT   = 6'b101010;
    localparam logic [OP_W-1:0] OP_SLTU  = 6'b101011;
endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational ALU: result, carry, overflow and illegal-op flag
module alu_core #(
    parameter int DATA_W = 8,
    parameter int OP_W   = 6
) (
    input  logic [OP_W-1:0]   i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_result,
    output logic              o_c,
    output logic              o_v,
    output logic              o_err
);
    import alu_pkg::*;

    localparam int SH_W = $clog2(DATA_W);
    localparam int MSB  = DATA_W - 1;

    logic [SH_W-1:0]   w_sh;
    logic [DATA_W:0]   w_sum;
    logic [DATA_W:0]   w_diff;
    logic              w_lt_s;
    logic              w_lt_u;

    assign w_sh   = i_b[SH_W-1:0];
    // One extra bit so the top bit is carry (add) or borrow (sub)
    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff = {1'b0, i_a} - {1'b0, i_b};
    assign w_lt_s = $signed(i_a) < $signed(i_b);
    assign w_lt_u = i_a < i_b;

    always_comb begin
        o_result = '0;
        o_c      = 1'b0;
        o_v      = 1'b0;
        o_err    = 1'b0;
        case (i_op)
            OP_ADD: begin
                o_result = w_sum[MSB:0];
                o_c      = w_sum[DATA_W];
                o_v      = (i_a[MSB] == i_b[MSB]) && (w_sum[MSB] != i_a[MSB]);
            end
            OP_SUB: begin
                o_result = w_diff[MSB:0];
                o_c      = !w_diff[DATA_W];
                o_v      = (i_a[MSB] != i_b[MSB]) && (w_diff[MSB] != i_a[MSB]);
            end
            OP_AND:   o_result = i_a & i_b;
            OP_OR:    o_result = i_a | i_b;
            OP_XOR:   o_result = i_a ^ i_b;
            OP_NOR:   o_result = ~(i_a | i_b);
            OP_SRA:   o_result = $signed(i_a) >>> w_sh;
            OP_SRL:   o_result = i_a >> w_sh;
            OP_SLL:   o_result = i_a << w_sh;
            OP_SLT:   o_result = {{(DATA_W-1){1'b0}}, w_lt_s};
            OP_SLTU:  o_result = {{(DATA_W-1){1'b0}}, w_lt_u};
            OP_PASSA: o_result = i_a;
            OP_PASSB: o_result = i_b;
            default: begin
                o_result = '1;
                o_err    = 1'b1;
            end
        endcase
    end
endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - two-stage ALU pipeline with valid/ready handshake and status flags
module alu_pipe #(
    parameter int DATA_W = 8,
    parameter int OP_W   = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   Op,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] Result,
    output logic              flag_z,
    output logic              flag_n,
    output logic              flag_c,
    output logic              flag_v,
    output logic              err
);
    logic              r_s1_valid;
    logic [OP_W-1:0]   r_s1_op;
    logic [DATA_W-1:0] r_s1_a;
    logic [DATA_W-1:0] r_s1_b;
    logic              r_s2_valid;
    logic [DATA_W-1:0] r_result;
    logic              r_z, r_n, r_c, r_v, r_err;

    logic              w_s1_en;
    logic              w_s2_en;
    logic [DATA_W-1:0] w_result;
    logic              w_c, w_v, w_err;

    // S2 frees up when empty or being taken; S1 frees up when empty or moving into S2
    assign w_s2_en  = !r_s2_valid || out_ready;
    assign w_s1_en  = !r_s1_valid || w_s2_en;
    assign in_ready = w_s1_en;

    alu_core #(.DATA_W(DATA_W), .OP_W(OP_W)) u_core (
        .i_op     (r_s1_op),
        .i_a      (r_s1_a),
        .i_b      (r_s1_b),
        .o_result (w_result),
        .o_c      (w_c),
        .o_v      (w_v),
        .o_err    (w_err)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= '0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
        end else if (w_s1_en) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_op <= Op;
                r_s1_a  <= A;
                r_s1_b  <= B;
            end
        end
    end

    // Output data only changes when a real op moves in, so it holds across bubbles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s2_valid <= 1'b0;
            r_result   <= '0;
            r_z        <= 1'b0;
            r_n        <= 1'b0;
            r_c        <= 1'b0;
            r_v        <= 1'b0;
            r_err      <= 1'b0;
        end else if (w_s2_en) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_result <= w_result;
                r_z      <= (w_result == '0);
                r_n      <= w_result[DATA_W-1];
                r_c      <= w_c;
                r_v      <= w_v;
                r_err    <= w_err;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign Result    = r_result;
    assign flag_z    = r_z;
    assign flag_n    = r_n;
    assign flag_c    = r_c;
    assign flag_v    = r_v;
    assign err       = r_err;
endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - directed self-checking bench for alu_pipe
module tb_alu_pipe;
    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] Op;
    logic [7:0] A;
    logic [7:0] B;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] Result;
    logic       flag_z, flag_n, flag_c, flag_v, err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_pipe #(.DATA_W(8), .OP_W(6)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Op        (Op),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Result    (Result),
        .flag_z    (flag_z),
        .flag_n    (flag_n),
        .flag_c    (flag_c),
        .flag_v    (flag_v),
        .err       (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // flags packed as {z,n,c,v,err}
    task automatic do_op(input string tag, input logic [5:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] exp_res, input logic [4:0] exp_fl);
        in_valid = 1'b1; Op = op; A = a; B = b;
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_lat1"}, {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_res"}, {24'd0, Result}, {24'd0, exp_res});
        chk({tag, "_flags"}, {27'd0, flag_z, flag_n, flag_c, flag_v, err}, {27'd0, exp_fl});
    endtask

    logic [7:0] exp_q [5];
    int         sent, rcv, stall_cnt;
    logic       saw_stall;
    logic [7:0] held;

    initial begin
        reset = 1'b1; in_valid = 1'b0; Op = '0; A = '0; B = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", {24'd0, Result}, 32'd0);
        chk("rst_flags", {27'd0, flag_z, flag_n, flag_c, flag_v, err}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);

        do_op("add_ovf",  6'b100000, 8'h7F, 8'h01, 8'h80, 5'b01010);
        do_op("add_wrap", 6'b100000, 8'hFF, 8'h01, 8'h00, 5'b10100);
        do_op("sub_eq",   6'b100010, 8'h05, 8'h05, 8'h00, 5'b10100);
        do_op("sub_brw",  6'b100010, 8'h00, 8'h01, 8'hFF, 5'b01000);
        do_op("sub_sovf", 6'b100010, 8'h80, 8'h01, 8'h7F, 5'b00110);
        do_op("sra",      6'b000011, 8'h80, 8'h0B, 8'hF0, 5'b01000);
        do_op("srl",      6'b000010, 8'h80, 8'h0B, 8'h10, 5'b00000);
        do_op("sll",      6'b000100, 8'h81, 8'h01, 8'h02, 5'b00000);
        do_op("slt",      6'b101010, 8'hFF, 8'h01, 8'h01, 5'b00000);
        do_op("sltu",     6'b101011, 8'hFF, 8'h01, 8'h00, 5'b10000);
        do_op("and",      6'b100100, 8'hF0, 8'h3C, 8'h30, 5'b00000);
        do_op("or",       6'b100101, 8'hF0, 8'h0C, 8'hFC, 5'b01000);
        do_op("xor",      6'b100110, 8'hFF, 8'h0F, 8'hF0, 5'b01000);
        do_op("nor",      6'b100111, 8'hF0, 8'h0F, 8'h00, 5'b10000);
        do_op("passa",    6'b000000, 8'h5A, 8'hA5, 8'h5A, 5'b00000);
        do_op("passb",    6'b000001, 8'h5A, 8'hA5, 8'hA5, 5'b01000);
        do_op("illegal",  6'b111111, 8'h12, 8'h34, 8'hFF, 5'b01001);
        do_op("legal_after", 6'b100000, 8'h01, 8'h01, 8'h02, 5'b00000);
        @(negedge clk);
        chk("hold_valid_low", {31'd0, out_valid}, 32'd0);
        chk("hold_result", {24'd0, Result}, 32'h02);

        // Stream of 5 ADDs with a 4-cycle consumer stall starting at the 2nd result
        for (int i = 0; i < 5; i++) exp_q[i] = 8'((i + 1) * 8'h11);
        sent = 0; rcv = 0; stall_cnt = 0; saw_stall = 1'b0; held = '0;
        for (int cyc = 0; cyc < 40 && rcv < 5; cyc++) begin
            if (out_valid && rcv == 1 && stall_cnt < 4) begin
                out_ready = 1'b0;
                if (stall_cnt == 0) held = Result;
                else chk("stall_stable", {24'd0, Result}, {24'd0, held});
                stall_cnt++;
            end else begin
                out_ready = 1'b1;
            end
            if (sent < 5) begin
                in_valid = 1'b1; Op = 6'b100000;
                A = 8'((sent + 1) * 8'h10); B = 8'(sent + 1);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && out_ready) begin
                chk("stream_res", {24'd0, Result}, {24'd0, exp_q[rcv]});
                rcv++;
            end
            if (in_valid && !in_ready) saw_stall = 1'b1;
            if (in_valid && in_ready) sent++;
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("stream_count", rcv, 32'd5);
        chk("stream_backpressure", {31'd0, saw_stall}, 32'd1);
        chk("stream_stall_len", stall_cnt, 32'd4);
        repeat (2) begin
            chk("stream_no_dup", {31'd0, out_valid}, 32'd0);
            @(negedge clk);
        end

        // Reset while two ops are in flight
        out_ready = 1'b0;
        in_valid = 1'b1; Op = 6'b100000; A = 8'h21; B = 8'h01;
        @(negedge clk);
        A = 8'h31;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("inflight_valid", {31'd0, out_valid}, 32'd1);
        chk("inflight_full", {31'd0, in_ready}, 32'd0);
        reset = 1'b1;
        #1;
        chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("async_rst_result", {24'd0, Result}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0; out_ready = 1'b1;
        #1;
        chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_no_stale", {31'd0, out_valid}, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
